// File: rtl/ib_cnu_f2_lut_loader_pkg.sv
// Shared definitions for the IB-CNU LUT stage loaders (f0..f3).
package ib_cnu_f2_lut_loader_pkg;

    // Number of pages per frame: one address bit is reserved for the frame offset.
    function automatic int unsigned page_num(input int unsigned entry_addr);
        return 32'd1 << (entry_addr - 32'd1);
    endfunction

    localparam int unsigned ENTRY_ADDR_DEF = 6;
    localparam int unsigned PAGE_NUM       = page_num(ENTRY_ADDR_DEF);

    // Loader FSM: waiting for a request, expecting the bank0 entry, expecting the bank1 entry.
    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StFillB0 = 2'd1,
        StFillB1 = 2'd2
    } lut_load_state_e;

endpackage

// File: rtl/ib_lut_pair_packer.sv
// Holds the bank0 entry of a page and presents the {bank0, bank1} page word.
module ib_lut_pair_packer #(
    parameter int unsigned LUT_PORT_SIZE = 3
) (
    input  logic                       write_clk,
    input  logic                       rstn,
    input  logic                       bank0_we,
    input  logic [LUT_PORT_SIZE-1:0]   entry,
    output logic [2*LUT_PORT_SIZE-1:0] pair
);

    logic [LUT_PORT_SIZE-1:0] bank0_q;

    // Capture the bank0 entry until its bank1 partner arrives.
    always_ff @(posedge write_clk or negedge rstn) begin
        if (!rstn) begin
            bank0_q <= '0;
        end else if (bank0_we) begin
            bank0_q <= entry;
        end
    end

    // Bank1 is taken straight from the incoming beat so the word is ready on its transfer edge.
    always_comb begin
        pair = {bank0_q, entry};
    end

endmodule

// File: rtl/ib_cnu_f2_lut_loader.sv
// Streams bank entries into the shared f2 LUT RAM write port, one page per entry pair.
module ib_cnu_f2_lut_loader
    import ib_cnu_f2_lut_loader_pkg::*;
#(
    parameter int unsigned ENTRY_ADDR      = 6,
    parameter int unsigned MULTI_FRAME_NUM = 2,
    parameter int unsigned BANK_NUM        = 2,
    parameter int unsigned LUT_PORT_SIZE   = 3
) (
    input  logic                              write_clk,
    input  logic                              rstn,
    input  logic                              load_start,
    input  logic                              load_frame,
    input  logic                              load_abort,
    input  logic [LUT_PORT_SIZE-1:0]          lut_in_data,
    input  logic                              lut_in_valid,
    output logic                              lut_in_ready,
    output logic [ENTRY_ADDR-1:0]             page_addr_ram,
    output logic [LUT_PORT_SIZE*BANK_NUM-1:0] ram_write_data_2,
    output logic                              ib_ram_we,
    output logic                              load_busy,
    output logic                              load_done
);

    localparam int unsigned FrameW = (MULTI_FRAME_NUM > 1) ? $clog2(MULTI_FRAME_NUM) : 1;
    localparam int unsigned PageW  = ENTRY_ADDR - FrameW;
    localparam int unsigned DataW  = LUT_PORT_SIZE * BANK_NUM;
    localparam logic [PageW-1:0] LastPage = PageW'(page_num(ENTRY_ADDR) - 32'd1);

    lut_load_state_e state_q, state_d;

    logic [PageW-1:0]  page_q;
    logic [FrameW-1:0] frame_q;

    logic              xfer;
    logic              start_load;
    logic              bank0_we;
    logic              write_fire;
    logic              done_fire;
    logic [DataW-1:0]  pair;

    logic              we_q;
    logic              done_q;
    logic [ENTRY_ADDR-1:0] addr_q;
    logic [DataW-1:0]  data_q;

    assign xfer = lut_in_valid & lut_in_ready;

    // State register.
    always_ff @(posedge write_clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; the final write of a frame completes even if abort coincides with it.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (load_start && !load_abort) begin
                    state_d = StFillB0;
                end
            end
            StFillB0: begin
                if (load_abort) begin
                    state_d = StIdle;
                end else if (xfer) begin
                    state_d = StFillB1;
                end
            end
            StFillB1: begin
                if (done_fire) begin
                    state_d = StIdle;
                end else if (write_fire) begin
                    state_d = StFillB0;
                end else if (load_abort) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Per-state controls: handshake, busy flag and the strobes that drive the datapath.
    always_comb begin
        lut_in_ready = 1'b0;
        load_busy    = 1'b0;
        start_load   = 1'b0;
        bank0_we     = 1'b0;
        write_fire   = 1'b0;
        done_fire    = 1'b0;
        unique case (state_q)
            StIdle: begin
                start_load = load_start & ~load_abort;
            end
            StFillB0: begin
                lut_in_ready = 1'b1;
                load_busy    = 1'b1;
                bank0_we     = lut_in_valid & ~load_abort;
            end
            StFillB1: begin
                lut_in_ready = 1'b1;
                load_busy    = 1'b1;
                write_fire   = lut_in_valid & (~load_abort | (page_q == LastPage));
                done_fire    = write_fire & (page_q == LastPage);
            end
            default: begin
                lut_in_ready = 1'b0;
            end
        endcase
    end

    // Frame latch and page counter; load_start while busy never reaches here.
    always_ff @(posedge write_clk or negedge rstn) begin
        if (!rstn) begin
            page_q  <= '0;
            frame_q <= '0;
        end else if (start_load) begin
            page_q  <= '0;
            frame_q <= FrameW'(load_frame);
        end else if (write_fire) begin
            page_q  <= page_q + PageW'(1);
        end
    end

    // Registered write port; address and data hold between strobes.
    always_ff @(posedge write_clk or negedge rstn) begin
        if (!rstn) begin
            we_q   <= 1'b0;
            done_q <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            we_q   <= write_fire;
            done_q <= done_fire;
            if (write_fire) begin
                addr_q <= {frame_q, page_q};
                data_q <= pair;
            end
        end
    end

    ib_lut_pair_packer #(
        .LUT_PORT_SIZE (LUT_PORT_SIZE)
    ) u_packer (
        .write_clk (write_clk),
        .rstn      (rstn),
        .bank0_we  (bank0_we),
        .entry     (lut_in_data),
        .pair      (pair)
    );

    assign ib_ram_we        = we_q;
    assign load_done        = done_q;
    assign page_addr_ram    = addr_q;
    assign ram_write_data_2 = data_q;

endmodule

// File: tb/tb_ib_cnu_f2_lut_loader.sv
// Directed bench for the f2 LUT loader with a per-cycle behavioural reference.
module tb_ib_cnu_f2_lut_loader;

    logic       write_clk;
    logic       rstn;
    logic       load_start;
    logic       load_frame;
    logic       load_abort;
    logic [2:0] lut_in_data;
    logic       lut_in_valid;
    logic       lut_in_ready;
    logic [5:0] page_addr_ram;
    logic [5:0] ram_write_data_2;
    logic       ib_ram_we;
    logic       load_busy;
    logic       load_done;

    int n_tests = 0;
    int n_fail  = 0;

    ib_cnu_f2_lut_loader #(
        .ENTRY_ADDR      (6),
        .MULTI_FRAME_NUM (2),
        .BANK_NUM        (2),
        .LUT_PORT_SIZE   (3)
    ) dut (
        .write_clk        (write_clk),
        .rstn             (rstn),
        .load_start       (load_start),
        .load_frame       (load_frame),
        .load_abort       (load_abort),
        .lut_in_data      (lut_in_data),
        .lut_in_valid     (lut_in_valid),
        .lut_in_ready     (lut_in_ready),
        .page_addr_ram    (page_addr_ram),
        .ram_write_data_2 (ram_write_data_2),
        .ib_ram_we        (ib_ram_we),
        .load_busy        (load_busy),
        .load_done        (load_done)
    );

    initial write_clk = 1'b0;
    always #5 write_clk = ~write_clk;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a load is a count of accepted entries (0..63); odd entries complete a page.
    bit       m_active;
    bit       m_frame;
    int       m_n;
    bit [2:0] m_hold;
    bit       exp_we, exp_done;
    bit [5:0] exp_addr, exp_data;

    always @(posedge write_clk or negedge rstn) begin
        if (!rstn) begin
            m_active = 0; m_frame = 0; m_n = 0; m_hold = 0;
            exp_we = 0; exp_done = 0; exp_addr = 0; exp_data = 0;
        end else begin
            exp_we   = 0;
            exp_done = 0;
            if (!m_active) begin
                if (load_start && !load_abort) begin
                    m_active = 1;
                    m_frame  = load_frame;
                    m_n      = 0;
                end
            end else if (lut_in_valid && (m_n % 2 == 1) && (!load_abort || m_n == 63)) begin
                exp_we   = 1;
                exp_addr = 6'(m_frame * 32 + m_n / 2);
                exp_data = 6'(m_hold * 8 + lut_in_data);
                if (m_n == 63) begin
                    exp_done = 1;
                    m_active = 0;
                end
                m_n++;
            end else if (load_abort) begin
                m_active = 0;
            end else if (lut_in_valid) begin
                m_hold = lut_in_data;
                m_n++;
            end
        end
    end

    // Observed writes, used by the literal checks that pin the reference itself.
    int       wr_count;
    bit [5:0] wr_addr [64];
    bit [5:0] wr_data [64];
    int       done_cnt;
    bit [5:0] done_addr;

    // Per-cycle comparison against the reference, away from the active edge.
    always @(negedge write_clk) begin
        if (rstn) begin
            chk("ready", int'(lut_in_ready), int'(m_active));
            chk("busy", int'(load_busy), int'(m_active));
            chk("we", int'(ib_ram_we), int'(exp_we));
            chk("done", int'(load_done), int'(exp_done));
            chk("addr", int'(page_addr_ram), int'(exp_addr));
            chk("data", int'(ram_write_data_2), int'(exp_data));
            if (ib_ram_we && wr_count < 64) begin
                wr_addr[wr_count] = page_addr_ram;
                wr_data[wr_count] = ram_write_data_2;
                wr_count++;
            end
            if (load_done) begin
                done_cnt++;
                done_addr = page_addr_ram;
            end
        end
    end

    task automatic step();
        @(posedge write_clk);
        #2;
    endtask

    task automatic clear_log();
        wr_count = 0;
        done_cnt = 0;
        done_addr = 0;
    endtask

    task automatic start(input bit frame);
        load_start = 1'b1;
        load_frame = frame;
        step();
        load_start = 1'b0;
    endtask

    // Send one entry (ready is high while loading) followed by idle gap cycles.
    task automatic send(input int v, input int gap);
        lut_in_valid = 1'b1;
        lut_in_data  = 3'(v);
        step();
        lut_in_valid = 1'b0;
        for (int g = 0; g < gap; g++) step();
    endtask

    initial begin
        rstn = 1'b0; load_start = 0; load_frame = 0; load_abort = 0;
        lut_in_data = 0; lut_in_valid = 0;
        clear_log();
        #12;
        chk("reset_we", int'(ib_ram_we), 0);
        chk("reset_addr", int'(page_addr_ram), 0);
        chk("reset_busy", int'(load_busy), 0);
        @(posedge write_clk); #2;
        rstn = 1'b1;
        step();

        // Frame 1, back-to-back entries i mod 8.
        clear_log();
        start(1'b1);
        for (int i = 0; i < 64; i++) send(i % 8, 0);
        step(); step();
        chk("t1_count", wr_count, 32);
        chk("t1_addr0", int'(wr_addr[0]), 'h20);
        chk("t1_data0", int'(wr_data[0]), 'o01);
        chk("t1_data1", int'(wr_data[1]), 'o23);
        chk("t1_addr31", int'(wr_addr[31]), 'h3F);
        chk("t1_done_cnt", done_cnt, 1);
        chk("t1_done_addr", int'(done_addr), 'h3F);
        chk("t1_busy_after", int'(load_busy), 0);

        // Frame 0 with three idle cycles between entries.
        clear_log();
        start(1'b0);
        for (int i = 0; i < 64; i++) send(i % 8, 3);
        step();
        chk("t2_count", wr_count, 32);
        chk("t2_addr0", int'(wr_addr[0]), 'h00);
        chk("t2_data1", int'(wr_data[1]), 'o23);
        chk("t2_addr31", int'(wr_addr[31]), 'h1F);
        chk("t2_done_cnt", done_cnt, 1);

        // Abort after five pages plus a pending bank0 entry.
        clear_log();
        start(1'b1);
        for (int i = 0; i < 11; i++) send(i % 8, 0);
        load_abort = 1'b1;
        step();
        load_abort = 1'b0;
        chk("t3_busy_drop", int'(load_busy), 0);
        for (int k = 0; k < 4; k++) step();
        chk("t3_count", wr_count, 5);
        chk("t3_no_done", done_cnt, 0);
        clear_log();
        start(1'b0);
        send(6, 0);
        send(5, 0);
        step();
        chk("t3_restart_addr", int'(wr_addr[0]), 'h00);
        chk("t3_restart_data", int'(wr_data[0]), 'o65);
        load_abort = 1'b1;
        step();
        load_abort = 1'b0;

        // load_start with the other frame while busy at page 10.
        clear_log();
        start(1'b1);
        for (int i = 0; i < 64; i++) begin
            load_start = (i == 20);
            load_frame = (i != 20);
            send(i % 8, 0);
        end
        load_start = 1'b0;
        step();
        chk("t4_count", wr_count, 32);
        chk("t4_addr10", int'(wr_addr[10]), 'h2A);
        chk("t4_addr31", int'(wr_addr[31]), 'h3F);

        // Start and abort together in idle.
        load_start = 1'b1; load_abort = 1'b1;
        step();
        load_start = 1'b0; load_abort = 1'b0;
        chk("t5_start_abort_busy", int'(load_busy), 0);

        // valid while idle is not accepted.
        clear_log();
        lut_in_valid = 1'b1; lut_in_data = 3'd4;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("t5_idle_ready", int'(lut_in_ready), 0);
        end
        lut_in_valid = 1'b0;
        chk("t5_idle_we", wr_count, 0);

        // Asynchronous reset during page 7.
        start(1'b0);
        for (int i = 0; i < 15; i++) send(i % 8, 0);
        #1;
        chk("t5_pre_reset_addr", int'(page_addr_ram), 'h06);
        rstn = 1'b0;
        #1;
        chk("t5_rst_addr", int'(page_addr_ram), 0);
        chk("t5_rst_data", int'(ram_write_data_2), 0);
        chk("t5_rst_busy", int'(load_busy), 0);
        chk("t5_rst_ready", int'(lut_in_ready), 0);
        chk("t5_rst_we", int'(ib_ram_we), 0);
        step();
        rstn = 1'b1;
        step();

        // Abort coinciding with the final bank1 transfer.
        clear_log();
        start(1'b1);
        for (int i = 0; i < 63; i++) send(i % 8, 0);
        load_abort = 1'b1;
        send(7, 0);
        load_abort = 1'b0;
        step();
        chk("t6_count", wr_count, 32);
        chk("t6_done_cnt", done_cnt, 1);
        chk("t6_done_addr", int'(done_addr), 'h3F);

        step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
